// File: rtl/lift_call_encoder.sv
// Lift8 call front end: synchronises and debounces the floor buttons, latches calls as
// pending (lamp drive), and offers them round-robin to the car controller over valid/ready.
module lift_call_encoder #(
    parameter int NUM_FLOORS      = 8,
    parameter int FLOOR_W         = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  door_open,
    input  logic                  emergency_stop,
    output logic                  req_valid,
    output logic [FLOOR_W-1:0]    req_floor,
    input  logic                  req_ready,
    output logic [NUM_FLOORS-1:0] pending
);
    // state | meaning
    // IDLE  | no offer outstanding; picks the next candidate call
    // OFFER | req_floor presented with req_valid=1, held until handshake or withdrawal
    typedef enum logic {IDLE, OFFER} state_t;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t                  state, state_next;
    logic [NUM_FLOORS-1:0]   sync1, sync2, deb, deb_d;
    logic [CNT_W-1:0]        cnt [NUM_FLOORS];
    logic [NUM_FLOORS-1:0]   pending_q, issued;
    logic [FLOOR_W-1:0]      rr_ptr, req_floor_q, req_floor_next, sel;
    logic [NUM_FLOORS-1:0]   press, serve, candidate, issued_set;
    logic                    found, handshake;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < NUM_FLOORS; i++) cnt[i] <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_TC) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        press     = deb & ~deb_d;
        candidate = pending_q & ~issued;
        serve     = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            serve[i] = door_open && (current_floor == FLOOR_W'(i));
    end

    // Rotating priority search starting at rr_ptr; FLOOR_W-bit addition wraps 7->0.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_FLOORS; k++) begin
            if (!found && candidate[rr_ptr + FLOOR_W'(k)]) begin
                sel   = rr_ptr + FLOOR_W'(k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state;
        req_floor_next = req_floor_q;
        handshake      = 1'b0;
        req_valid      = (state == OFFER);
        case (state)
            IDLE: begin
                if (!emergency_stop && found) begin
                    req_floor_next = sel;
                    state_next     = OFFER;
                end
            end
            OFFER: begin
                if (emergency_stop) begin
                    state_next = IDLE;
                end else if (req_ready) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end else if (serve[req_floor_q]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        issued_set = handshake ? (NUM_FLOORS'(1) << req_floor_q) : '0;
    end

    // Service of a floor wins over a same-cycle press or acceptance of that floor.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            req_floor_q <= '0;
            pending_q   <= '0;
            issued      <= '0;
            rr_ptr      <= '0;
        end else begin
            state       <= state_next;
            req_floor_q <= req_floor_next;
            if (handshake) rr_ptr <= req_floor_q + FLOOR_W'(1);
            if (emergency_stop) begin
                pending_q <= '0;
                issued    <= '0;
            end else begin
                pending_q <= (pending_q | press) & ~serve;
                issued    <= (issued | issued_set) & ~serve;
            end
        end
    end

    assign req_floor = req_floor_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_lift_call_encoder.sv
// Bench for lift_call_encoder: directed scenarios plus randomized press sets, with an
// expected-offer queue drained by an independent handshake monitor.
module tb_lift_call_encoder;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] btn;
    logic [2:0] current_floor;
    logic       door_open;
    logic       emergency_stop;
    logic       req_valid;
    logic [2:0] req_floor;
    logic       req_ready;
    logic [7:0] pending;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int model_ptr = 0;

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [2:0] prev_floor = '0;

    lift_call_encoder #(.NUM_FLOORS(8), .FLOOR_W(3), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .btn(btn), .current_floor(current_floor),
        .door_open(door_open), .emergency_stop(emergency_stop), .req_valid(req_valid),
        .req_floor(req_floor), .req_ready(req_ready), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Calls latched together are offered in ascending floor order starting at the
    // pointer, wrapping; the pointer then sits just past the last accepted floor.
    task automatic push_expected(input logic [7:0] mask);
        int f;
        int last;
        last = -1;
        for (int k = 0; k < 8; k++) begin
            f = (model_ptr + k) % 8;
            if (mask[f]) begin
                exp_q.push_back(f);
                last = f;
            end
        end
        if (last >= 0) model_ptr = (last + 1) % 8;
    endtask

    task automatic wait_valid(input int max);
        int c;
        c = 0;
        while (!req_valid && c < max) begin
            tick();
            c++;
        end
        check("wait_valid", req_valid, 1);
    endtask

    task automatic drain(input int max, input bit rnd, input int release_at);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < max) begin
            if (rnd) req_ready = 1'($urandom % 2);
            if (c == release_at) btn = '0;
            tick();
            c++;
        end
        btn = '0;
        check("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic serve(input int f);
        current_floor = 3'(f);
        door_open = 1'b1;
        tick();
        door_open = 1'b0;
        check("serve_clear", pending[f], 0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (req_valid && req_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_offer: got floor %0d expected none", req_floor);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (req_floor !== 3'(e)) begin
                        n_fail++;
                        $display("FAIL offer_order: got floor %0d expected %0d", req_floor, e);
                    end
                end
            end
            if (prev_valid && !prev_ready && req_valid) begin
                n_tests++;
                if (req_floor !== prev_floor) begin
                    n_fail++;
                    $display("FAIL offer_stable: got floor %0d expected %0d", req_floor, prev_floor);
                end
            end
            prev_valid = req_valid;
            prev_ready = req_ready;
            prev_floor = req_floor;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   pat[5] = '{1, 0, 1, 1, 0};
        logic bad;
        int   f;
        int   len;
        logic [7:0] mask;

        reset = 1'b0; btn = '0; current_floor = '0; door_open = 1'b0;
        emergency_stop = 1'b0; req_ready = 1'b0;
        tick(2);
        check("reset_valid", req_valid, 0);
        check("reset_floor", req_floor, 0);
        check("reset_pending", pending, 0);

        // single press, latency, acceptance and service
        reset = 1'b1;
        btn = 8'h08;
        push_expected(8'h08);
        tick(6);
        check("latency_early", pending, 8'h00);
        tick();
        check("latency_pending", pending, 8'h08);
        check("latency_no_valid", req_valid, 0);
        tick();
        check("first_valid", req_valid, 1);
        check("first_floor", req_floor, 3);
        req_ready = 1'b1;
        tick();
        check("accept_drop", req_valid, 0);
        check("issued_pending", pending, 8'h08);
        req_ready = 1'b0;
        btn = '0;
        tick(4);
        check("no_reoffer", req_valid, 0);
        check("queue_empty", exp_q.size(), 0);
        serve(3);

        // glitch filtering
        btn[4] = 1'b1; tick(2); btn[4] = 1'b0; tick(2);
        for (int i = 0; i < 5; i++) begin
            btn[4] = pat[i][0];
            tick();
        end
        btn = '0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (req_valid) bad = 1'b1;
        end
        check("glitch_no_offer", bad, 0);
        check("glitch_pending", pending, 0);

        // round robin with wrap
        reset = 1'b0; tick(); reset = 1'b1; model_ptr = 0;
        req_ready = 1'b1;
        btn = 8'h24;
        push_expected(8'h24);
        drain(60, 1'b0, 8);
        check("rr_pending", pending, 8'h24);
        tick(8);
        btn = 8'h02;
        push_expected(8'h02);
        drain(60, 1'b0, 8);
        check("wrap_pending", pending, 8'h26);
        req_ready = 1'b0;
        serve(2); serve(5); serve(1);
        check("rr_cleared", pending, 0);

        // backpressure
        btn = 8'h40;
        push_expected(8'h40);
        wait_valid(20);
        check("bp_floor", req_floor, 6);
        btn = 8'h01;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!req_valid || req_floor != 3'd6) bad = 1'b1;
        end
        check("bp_hold", bad, 0);
        check("bp_pending", pending, 8'h41);
        push_expected(8'h01);
        btn = '0;
        req_ready = 1'b1;
        tick();
        check("bp_idle_gap", req_valid, 0);
        tick();
        check("bp_next_valid", req_valid, 1);
        check("bp_next_floor", req_floor, 0);
        tick();
        req_ready = 1'b0;
        check("bp_drained", exp_q.size(), 0);
        serve(6); serve(0);

        // press while served is dropped; service withdraws an offer
        tick(8);
        current_floor = 3'd2; door_open = 1'b1;
        btn = 8'h04;
        tick(8);
        btn = '0;
        tick(4);
        check("served_press_dropped", pending, 0);
        check("served_no_offer", req_valid, 0);
        door_open = 1'b0; current_floor = 3'd0;
        btn = 8'h80;
        wait_valid(20);
        check("withdraw_floor", req_floor, 7);
        btn = '0;
        current_floor = 3'd7; door_open = 1'b1;
        tick();
        check("withdraw_valid", req_valid, 0);
        check("withdraw_pending", pending, 0);
        door_open = 1'b0; current_floor = 3'd0;
        req_ready = 1'b1;
        tick(3);
        check("withdraw_stays_idle", req_valid, 0);
        req_ready = 1'b0;

        // emergency stop flushes and masks
        tick(8);
        btn = 8'hA4;
        wait_valid(20);
        check("estop_pending_before", pending, 8'hA4);
        check("estop_offer_floor", req_floor, 2);
        btn = 8'hAC;
        tick(5);
        emergency_stop = 1'b1;
        tick();
        check("estop_valid", req_valid, 0);
        check("estop_pending", pending, 0);
        tick();
        emergency_stop = 1'b0;
        tick(3);
        check("estop_masks_press", pending, 0);
        check("estop_idle", req_valid, 0);
        btn = '0;
        tick(8);

        // async reset mid-offer, then full re-debounce
        btn = 8'h10;
        wait_valid(20);
        #1 reset = 1'b0;
        #1;
        check("arst_valid", req_valid, 0);
        check("arst_floor", req_floor, 0);
        check("arst_pending", pending, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        model_ptr = 0;
        tick(6);
        check("rearm_early", pending, 0);
        tick();
        check("rearm_pending", pending, 8'h10);
        push_expected(8'h10);
        req_ready = 1'b1;
        drain(40, 1'b0, 0);
        req_ready = 1'b0;
        serve(4);
        tick(8);

        // randomized glitches and press sets under random backpressure
        for (int it = 0; it < 8; it++) begin
            f = int'($urandom % 8);
            len = 1 + int'($urandom % (D - 1));
            btn[f] = 1'b1;
            tick(len);
            btn = '0;
            tick(8);
            check("rand_glitch", pending, 0);
            mask = 8'($urandom_range(1, 255));
            btn = mask;
            push_expected(mask);
            drain(400, 1'b1, 8);
            req_ready = 1'b0;
            check("rand_pending", pending, mask);
            for (int k = 0; k < 8; k++)
                if (mask[k]) serve(k);
            check("rand_cleared", pending, 0);
            tick(8);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
